// File: rtl/slave_reg_bank.sv
// Word-addressed slave register bank with independent write (addr/data/resp) and
// read (addr/data) valid-ready channels, each sequenced by a small two-state FSM.
module slave_reg_bank #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic              write_addr_valid,
    output logic              write_addr_ready,
    input  logic [DATA_W-1:0] write_data,
    input  logic              write_valid,
    output logic              write_ready,
    output logic              write_resp_valid,
    output logic              write_resp_err,
    input  logic              write_resp_ready,
    input  logic [ADDR_W-1:0] read_addr,
    input  logic              read_addr_valid,
    output logic              read_addr_ready,
    output logic [DATA_W-1:0] read_data,
    output logic              read_valid,
    output logic              read_err,
    input  logic              read_ready
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic { W_IDLE, W_RESP } wstate_t;
    typedef enum logic { R_IDLE, R_DATA } rstate_t;

    wstate_t wstate, wstate_nxt;
    rstate_t rstate, rstate_nxt;

    logic              live;
    logic [DATA_W-1:0] regs [NUM_REGS];

    logic              aw_got, w_got;
    logic [ADDR_W-1:0] aw_addr;
    logic [DATA_W-1:0] w_data;
    logic              aw_hs, w_hs, ar_hs;
    logic              wr_fire, wr_in_range, rd_in_range;
    logic [ADDR_W-1:0] wr_addr_eff;
    logic [DATA_W-1:0] wr_data_eff;
    logic [IDX_W-1:0]  wr_idx, rd_idx;

    logic              resp_err_q;
    logic              rd_err_q;
    logic [DATA_W-1:0] rd_data_q;

    // Write lands on the same edge as the later handshake, so the effective
    // address/data bypass the latches when that channel is handshaking now.
    assign wr_addr_eff = aw_got ? aw_addr : write_addr;
    assign wr_data_eff = w_got  ? w_data  : write_data;
    assign wr_in_range = {1'b0, wr_addr_eff} < LIMIT;
    assign rd_in_range = {1'b0, read_addr} < LIMIT;
    assign wr_idx      = wr_addr_eff[IDX_W-1:0];
    assign rd_idx      = read_addr[IDX_W-1:0];

    assign write_resp_err = resp_err_q;
    assign read_data      = rd_data_q;
    assign read_err       = rd_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate <= W_IDLE;
            rstate <= R_IDLE;
        end else begin
            wstate <= wstate_nxt;
            rstate <= rstate_nxt;
        end
    end

    always_comb begin
        wstate_nxt       = wstate;
        write_addr_ready = 1'b0;
        write_ready      = 1'b0;
        write_resp_valid = 1'b0;
        aw_hs            = 1'b0;
        w_hs             = 1'b0;
        wr_fire          = 1'b0;
        if (wstate == W_IDLE) begin
            write_addr_ready = live && !rst && !aw_got;
            write_ready      = live && !rst && !w_got;
            aw_hs            = write_addr_valid && write_addr_ready;
            w_hs             = write_valid && write_ready;
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                wr_fire    = 1'b1;
                wstate_nxt = W_RESP;
            end
        end else begin
            write_resp_valid = 1'b1;
            if (write_resp_ready) begin
                wstate_nxt = W_IDLE;
            end
        end
    end

    always_comb begin
        rstate_nxt      = rstate;
        read_addr_ready = 1'b0;
        read_valid      = 1'b0;
        ar_hs           = 1'b0;
        if (rstate == R_IDLE) begin
            read_addr_ready = live && !rst;
            ar_hs           = read_addr_valid && read_addr_ready;
            if (ar_hs) begin
                rstate_nxt = R_DATA;
            end
        end else begin
            read_valid = 1'b1;
            if (read_ready) begin
                rstate_nxt = R_IDLE;
            end
        end
    end

    // live keeps the ready outputs low until the first edge after reset release.
    always_ff @(posedge clk) begin
        if (rst) begin
            live       <= 1'b0;
            aw_got     <= 1'b0;
            w_got      <= 1'b0;
            aw_addr    <= '0;
            w_data     <= '0;
            resp_err_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            live <= 1'b1;
            if (aw_hs) begin
                aw_got  <= 1'b1;
                aw_addr <= write_addr;
            end
            if (w_hs) begin
                w_got  <= 1'b1;
                w_data <= write_data;
            end
            if (wr_fire) begin
                resp_err_q <= !wr_in_range;
                if (wr_in_range) begin
                    regs[wr_idx] <= wr_data_eff;
                end
            end
            if (wstate == W_RESP && write_resp_ready) begin
                aw_got     <= 1'b0;
                w_got      <= 1'b0;
                resp_err_q <= 1'b0;
            end
        end
    end

    // Samples regs before any same-edge write, giving read-before-write ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
            rd_err_q  <= 1'b0;
        end else if (ar_hs) begin
            if (rd_in_range) begin
                rd_data_q <= regs[rd_idx];
                rd_err_q  <= 1'b0;
            end else begin
                rd_data_q <= '0;
                rd_err_q  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_slave_reg_bank.sv
// Randomized self-checking bench for slave_reg_bank against an array-based
// model of the register contents; all stimulus and sampling on the falling edge.
module tb_slave_reg_bank;

    logic        master_clk = 1'b0;
    logic        rst;
    logic [7:0]  write_addr;
    logic        write_addr_valid;
    logic        write_addr_ready;
    logic [31:0] write_data;
    logic        write_valid;
    logic        write_ready;
    logic        write_resp_valid;
    logic        write_resp_err;
    logic        write_resp_ready;
    logic [7:0]  read_addr;
    logic        read_addr_valid;
    logic        read_addr_ready;
    logic [31:0] read_data;
    logic        read_valid;
    logic        read_err;
    logic        read_ready;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] model [16];

    always #5 master_clk = ~master_clk;

    slave_reg_bank #(.ADDR_W(8), .DATA_W(32), .NUM_REGS(16)) dut (
        .clk              (master_clk),
        .rst              (rst),
        .write_addr       (write_addr),
        .write_addr_valid (write_addr_valid),
        .write_addr_ready (write_addr_ready),
        .write_data       (write_data),
        .write_valid      (write_valid),
        .write_ready      (write_ready),
        .write_resp_valid (write_resp_valid),
        .write_resp_err   (write_resp_err),
        .write_resp_ready (write_resp_ready),
        .read_addr        (read_addr),
        .read_addr_valid  (read_addr_valid),
        .read_addr_ready  (read_addr_ready),
        .read_data        (read_data),
        .read_valid       (read_valid),
        .read_err         (read_err),
        .read_ready       (read_ready)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [7:0] a);
        return (a < 8'd16) ? model[a[3:0]] : 32'h0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d,
                            input int a_dly, input int d_dly, input int r_dly);
        int cyc;
        bit a_done, d_done, hs_a, hs_d;
        cyc = 0; a_done = 0; d_done = 0;
        write_addr = a;
        write_data = d;
        while (!(a_done && d_done)) begin
            write_addr_valid = !a_done && (cyc >= a_dly);
            write_valid      = !d_done && (cyc >= d_dly);
            hs_a = write_addr_valid && write_addr_ready;
            hs_d = write_valid && write_ready;
            @(negedge master_clk);
            a_done = a_done | hs_a;
            d_done = d_done | hs_d;
            cyc++;
            if (d_done && !a_done) check_eq("wready_low_after_data", write_ready, 0);
            if (a_done && !d_done) check_eq("awready_low_after_addr", write_addr_ready, 0);
            if (cyc > 64) begin
                check_eq("write_timeout", 0, 1);
                write_addr_valid = 0;
                write_valid = 0;
                return;
            end
        end
        write_addr_valid = 0;
        write_valid = 0;
        check_eq("bresp_valid", write_resp_valid, 1);
        check_eq("bresp_err", write_resp_err, (a >= 8'd16));
        if (a < 8'd16) model[a[3:0]] = d;
        for (int k = 0; k < r_dly; k++) begin
            write_addr = a ^ 8'h01;
            write_addr_valid = 1;
            write_valid = 1;
            check_eq("awready_low_in_resp", write_addr_ready, 0);
            check_eq("wready_low_in_resp", write_ready, 0);
            @(negedge master_clk);
            check_eq("bresp_valid_hold", write_resp_valid, 1);
            check_eq("bresp_err_hold", write_resp_err, (a >= 8'd16));
        end
        write_addr_valid = 0;
        write_valid = 0;
        write_resp_ready = 1;
        @(negedge master_clk);
        write_resp_ready = 0;
        check_eq("bresp_valid_drop", write_resp_valid, 0);
        check_eq("awready_back", write_addr_ready, 1);
    endtask

    task automatic do_read(input logic [7:0] a, input int r_dly);
        int cyc;
        logic [31:0] exp_d;
        cyc = 0;
        read_addr = a;
        read_addr_valid = 1;
        while (!read_addr_ready) begin
            @(negedge master_clk);
            cyc++;
            if (cyc > 64) begin
                check_eq("read_timeout", 0, 1);
                read_addr_valid = 0;
                return;
            end
        end
        exp_d = model_rd(a);
        @(negedge master_clk);
        read_addr_valid = 0;
        check_eq("rvalid", read_valid, 1);
        check_eq("rdata", read_data, exp_d);
        check_eq("rerr", read_err, (a >= 8'd16));
        for (int k = 0; k < r_dly; k++) begin
            check_eq("arready_low_in_rdata", read_addr_ready, 0);
            @(negedge master_clk);
            check_eq("rvalid_hold", read_valid, 1);
            check_eq("rdata_hold", read_data, exp_d);
        end
        read_ready = 1;
        @(negedge master_clk);
        read_ready = 0;
        check_eq("rvalid_drop", read_valid, 0);
        check_eq("arready_back", read_addr_ready, 1);
    endtask

    // Read handshake and completing write on the same edge: read sees the old value.
    task automatic rw_same(input logic [7:0] ra, input logic [7:0] wa, input logic [31:0] d);
        logic [31:0] exp_old;
        exp_old = model_rd(ra);
        write_addr = wa; write_data = d; read_addr = ra;
        write_addr_valid = 1; write_valid = 1; read_addr_valid = 1;
        check_eq("rw_all_ready", {write_addr_ready, write_ready, read_addr_ready}, 3'b111);
        @(negedge master_clk);
        write_addr_valid = 0; write_valid = 0; read_addr_valid = 0;
        if (wa < 8'd16) model[wa[3:0]] = d;
        check_eq("rw_rdata_old", read_data, exp_old);
        check_eq("rw_rerr", read_err, (ra >= 8'd16));
        check_eq("rw_bresp_valid", write_resp_valid, 1);
        check_eq("rw_bresp_err", write_resp_err, (wa >= 8'd16));
        write_resp_ready = 1; read_ready = 1;
        @(negedge master_clk);
        write_resp_ready = 0; read_ready = 0;
        check_eq("rw_valids_drop", {write_resp_valid, read_valid}, 2'b00);
    endtask

    task automatic read_all();
        for (int i = 0; i < 16; i++) do_read(8'(i), 0);
    endtask

    initial begin
        rst = 1;
        write_addr = '0; write_addr_valid = 0; write_data = '0; write_valid = 0;
        write_resp_ready = 0; read_addr = '0; read_addr_valid = 0; read_ready = 0;
        model_clear();

        repeat (3) @(negedge master_clk);
        check_eq("rst_readies", {write_addr_ready, write_ready, read_addr_ready}, 3'b000);
        check_eq("rst_valids", {write_resp_valid, write_resp_err, read_valid, read_err}, 4'b0000);
        check_eq("rst_rdata", read_data, 0);
        rst = 0;
        check_eq("release_readies_low", {write_addr_ready, write_ready, read_addr_ready}, 3'b000);
        @(negedge master_clk);
        check_eq("idle_readies", {write_addr_ready, write_ready, read_addr_ready}, 3'b111);

        do_write(8'h03, 32'hDEADBEEF, 0, 0, 0);
        do_read(8'h03, 0);
        do_write(8'h05, 32'h12345678, 3, 0, 0);
        do_read(8'h05, 2);
        do_write(8'h20, 32'hCAFEF00D, 0, 0, 0);
        do_read(8'h20, 0);
        read_all();
        do_write(8'h07, 32'h0BADC0DE, 1, 0, 5);
        do_read(8'h07, 0);
        rw_same(8'h03, 8'h03, 32'h0);
        do_read(8'h03, 0);

        for (int it = 0; it < 60; it++) begin
            logic [7:0] a, b;
            a = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
            b = 8'($urandom_range(0, 19));
            case ($urandom_range(0, 2))
                0: do_write(a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
                1: do_read(a, $urandom_range(0, 2));
                default: rw_same(b, a, $urandom);
            endcase
        end
        read_all();

        // Reset while the write FSM is in W_RESP and the read FSM in R_DATA.
        write_addr = 8'h09; write_data = 32'h5555AAAA; read_addr = 8'h03;
        write_addr_valid = 1; write_valid = 1; read_addr_valid = 1;
        @(negedge master_clk);
        write_addr_valid = 0; write_valid = 0; read_addr_valid = 0;
        check_eq("pre_rst_valids", {write_resp_valid, read_valid}, 2'b11);
        rst = 1;
        @(negedge master_clk);
        model_clear();
        check_eq("midrst_valids", {write_resp_valid, write_resp_err, read_valid, read_err}, 4'b0000);
        check_eq("midrst_rdata", read_data, 0);
        check_eq("midrst_readies", {write_addr_ready, write_ready, read_addr_ready}, 3'b000);
        rst = 0;
        check_eq("midrst_release_low", {write_addr_ready, write_ready, read_addr_ready}, 3'b000);
        @(negedge master_clk);
        check_eq("midrst_idle_readies", {write_addr_ready, write_ready, read_addr_ready}, 3'b111);
        read_all();

        // Data latched then reset: the stale data must not pair with a new address.
        write_data = 32'hA5A5A5A5; write_valid = 1;
        @(negedge master_clk);
        write_valid = 0;
        check_eq("partial_wready_low", write_ready, 0);
        rst = 1;
        @(negedge master_clk);
        rst = 0;
        @(negedge master_clk);
        check_eq("partial_wready_clear", write_ready, 1);
        write_addr = 8'h02; write_addr_valid = 1;
        @(negedge master_clk);
        write_addr_valid = 0;
        check_eq("partial_no_resp", write_resp_valid, 0);
        write_data = 32'h600DF00D; write_valid = 1;
        @(negedge master_clk);
        write_valid = 0;
        model[2] = 32'h600DF00D;
        check_eq("partial_resp", {write_resp_valid, write_resp_err}, 2'b10);
        write_resp_ready = 1;
        @(negedge master_clk);
        write_resp_ready = 0;
        read_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
